mem_arbiter_rr: RTL
===================

# mem_arbiter_rr

Parametrised round-robin memory-port arbiter with bus multiplexer. It grants one of `CHANNELS` requesters exclusive use of a shared memory port and steers that requester's address, write data and read/write strobe onto the port. An optional hold limit preempts requesters that keep the port too long. It replaces the fixed three-channel memory controller and sits between the requesting engines (e.g. text/flash/UART masters) and the shared memory.

## Interface
Parameters:
- `CHANNELS`, 3: number of requesters; legal range 2..16.
- `ADDR_W`, 8: address width.
- `DATA_W`, 32: write-data width.
- `MAX_HOLD`, 16: maximum consecutive grant cycles per tenure. 0 disables preemption.

Ports:
- `clk`  in  1: single clock, all logic on posedge.
- `rstN`  in  1: asynchronous, active-low reset.
- `requests`  in  CHANNELS: bit i high = channel i wants/holds the port.
- `addrIn`  in  CHANNELS*ADDR_W: channel i address at bits [i*ADDR_W +: ADDR_W].
- `dataIn`  in  CHANNELS*DATA_W: channel i write data, same packing.
- `readWriteIn`  in  CHANNELS: channel i strobe; 1 = write, 0 = read.
- `grantedAccess`  out  CHANNELS: one-hot grant, registered; all-zero when idle.
- `enabled`  out  1: high while a grant is active.
- `address`  out  ADDR_W: muxed address of the granted channel.
- `dataToMem`  out  DATA_W: muxed write data of the granted channel.
- `readWrite`  out  1: muxed strobe of the granted channel.
- `preempted`  out  1: one-cycle pulse when a tenure is ended by `MAX_HOLD`.

## Operation
- Registered state: `state` (IDLE/GRANT), `grantIdx`, `lastGrant`, `holdCount` (clog2(MAX_HOLD+1) bits, min 1), `preempted`.
- Reset (asynchronous, takes effect immediately): state=IDLE, `grantedAccess`=0, `enabled`=0, `preempted`=0, `holdCount`=0, `lastGrant`=CHANNELS-1, so channel 0 has first priority.
- IDLE:
  - `enabled`=0, `grantedAccess`=0, `address`/`dataToMem`/`readWrite` forced to 0.
  - Search channels `lastGrant`+1, +2, ... wrapping modulo CHANNELS. The first with `requests` high is the winner.
  - If a winner exists: on the next edge go to GRANT, `grantIdx`=winner, `holdCount`=1.
  - If no request: remain IDLE.
- GRANT:
  - `enabled`=1, `grantedAccess`=1<<`grantIdx`.
  - Outputs are a combinational mux of channel `grantIdx` inputs. Input changes are seen the same cycle.
  - If `requests[grantIdx]`=0 at an edge: go to IDLE, `lastGrant`=`grantIdx`. This is a normal release.
  - Else if MAX_HOLD≠0 and `holdCount`==MAX_HOLD at an edge: go to IDLE, `lastGrant`=`grantIdx`, `preempted`=1 for that IDLE cycle.
  - Otherwise stay in GRANT and increment `holdCount`.
- Requests from other channels never interrupt a grant. Only a release or preemption ends it.
- A preempted channel that still requests competes normally. Because `lastGrant` equals its index, it has lowest priority. If it is the sole requester, it is re-granted after the idle cycle.
- MAX_HOLD=0: `holdCount` saturates and never preempts.

## Timing
- Grant latency: a request visible at edge k while IDLE produces `grantedAccess`/`enabled` after edge k (1 cycle).
- Release latency: request low at edge k clears `enabled` after edge k.
- Exactly one IDLE cycle separates any two tenures. Back-to-back grants are not allowed.
- Max tenure is exactly MAX_HOLD cycles of `enabled`=1.
- Simultaneous new requests in IDLE are resolved by the round-robin search. No two bits of `grantedAccess` are ever high together.
- Reset mid-tenure: `enabled`, `grantedAccess` and the mux outputs go to 0 without a clock edge. After reset deasserts, arbitration restarts with channel 0 first.
- `preempted` is registered and high only during the IDLE cycle that follows a preemption.

## Test plan
All scenarios use CHANNELS=3, ADDR_W=8, DATA_W=32, MAX_HOLD=8 unless stated. Inputs: `addrIn` = {A3,A2,A1}, `dataIn` = {D3,D2,D1}, `readWriteIn` = 3'b010.
- All requests held high from reset:
  - Grants cycle 001→010→100→001, each 8 `enabled` cycles.
  - One idle cycle between tenures, with `preempted` pulsing in each gap.
- Each requester drops its request after 4 enabled cycles and re-raises it while `enabled`=0:
  - Grants cycle 001, 010, 100, each lasting 5 cycles.
  - `preempted` never asserts.
- Mux check:
  - During grant 010: `address`=A2, `dataToMem`=D2, `readWrite`=1.
  - During grant 001: A1, D1, 0.
  - In IDLE all three outputs are 0.
- Pointer wrap:
  - Only channel 2 requests: grant 100. Release it.
  - Then channels 0 and 2 request in the same cycle: grant 001.
  - Keep channel 2 requesting: after channel 0 releases, grant 100.
- Async reset during grant 010: `enabled` and `grantedAccess` go to 0 before the next edge. After `rstN` rises with all requests high, the first grant is 001.
- MAX_HOLD=0: channel 1 holds its request for 100 cycles → `grantedAccess`=010 for all 100 cycles, `preempted` stays 0.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr
//
// Round-robin arbiter for one shared memory port. CHANNELS requesters compete
// for the port. The winner holds it until it drops its request, or until it
// has held it for MAX_HOLD consecutive cycles (MAX_HOLD = 0 means no limit).
// While a channel holds the port, its address, write data and read/write
// strobe are steered onto the port.
//
// Ports
//   clk            : clock; all logic is on the rising edge
//   rstN           : asynchronous active-low reset
//   requests       : per-channel request; high means wants or holds the port
//   addrIn         : packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   dataIn         : packed channel write data, channel i at [i*DATA_W +: DATA_W]
//   readWriteIn    : per-channel strobe (1 = write, 0 = read)
//   grantedAccess  : registered one-hot grant; all zero when idle
//   enabled        : registered; high while a grant is active
//   address        : address of the granted channel; 0 when idle
//   dataToMem      : write data of the granted channel; 0 when idle
//   readWrite      : strobe of the granted channel; 0 when idle
//   preempted      : one-cycle pulse in the idle cycle after a forced release
// ---------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int CHANNELS = 3,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [CHANNELS-1:0]        requests,
    input  logic [CHANNELS*ADDR_W-1:0] addrIn,
    input  logic [CHANNELS*DATA_W-1:0] dataIn,
    input  logic [CHANNELS-1:0]        readWriteIn,
    output logic [CHANNELS-1:0]        grantedAccess,
    output logic                       enabled,
    output logic [ADDR_W-1:0]          address,
    output logic [DATA_W-1:0]          dataToMem,
    output logic                       readWrite,
    output logic                       preempted
);

    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    // After reset the pointer sits on the last channel, so channel 0 is
    // searched first.
    localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(CHANNELS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
    localparam bit                HOLD_EN    = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_n;
    logic [IDX_W-1:0]      grant_idx_r;
    logic [IDX_W-1:0]      grant_idx_n;
    logic [IDX_W-1:0]      last_grant_r;
    logic [IDX_W-1:0]      last_grant_n;
    logic [HOLD_W-1:0]     hold_count_r;
    logic [HOLD_W-1:0]     hold_count_n;
    logic                  preempted_r;
    logic                  preempted_n;
    logic [CHANNELS-1:0]   granted_r;
    logic [CHANNELS-1:0]   granted_n;
    logic                  enabled_r;
    logic                  enabled_n;

    logic                  found_s;
    logic [IDX_W-1:0]      winner_s;
    logic [IDX_W-1:0]      cand_s;

    logic [ADDR_W-1:0]     address_s;
    logic [DATA_W-1:0]     data_s;
    logic                  rw_s;

    // Round-robin search: first requester at last_grant+1, +2, ... (wrapping)
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IDX_W{1'b0}};
        cand_s   = {IDX_W{1'b0}};
        for (int i = 1; i <= CHANNELS; i++) begin
            cand_s = IDX_W'((int'(last_grant_r) + i) % CHANNELS);
            if (!found_s && requests[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Next-state logic for the IDLE/GRANT tenure FSM
    always_comb begin
        state_n      = state_r;
        grant_idx_n  = grant_idx_r;
        last_grant_n = last_grant_r;
        hold_count_n = hold_count_r;
        preempted_n  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_n      = ST_GRANT;
                    grant_idx_n  = winner_s;
                    hold_count_n = HOLD_ONE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!requests[grant_idx_r]) begin
                    // Voluntary release
                    state_n      = ST_IDLE;
                    last_grant_n = grant_idx_r;
                end else if (HOLD_EN && (hold_count_r == HOLD_LIMIT)) begin
                    // Tenure limit reached; the holder drops to lowest priority
                    state_n      = ST_IDLE;
                    last_grant_n = grant_idx_r;
                    preempted_n  = 1'b1;
                end else if (hold_count_r != HOLD_SAT) begin
                    hold_count_n = hold_count_r + HOLD_ONE;
                end else begin
                    // Unlimited mode: the counter parks at its maximum
                    hold_count_n = hold_count_r;
                end
            end
            default: begin
                state_n      = ST_IDLE;
                last_grant_n = LAST_RESET;
                hold_count_n = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Registered grant vector and enable derived from the next state
    always_comb begin
        granted_n = {CHANNELS{1'b0}};
        enabled_n = 1'b0;
        if (state_n == ST_GRANT) begin
            granted_n[grant_idx_n] = 1'b1;
            enabled_n              = 1'b1;
        end else begin
            enabled_n = 1'b0;
        end
    end

    // State and output registers; reset clears the port without a clock edge
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r      <= ST_IDLE;
            grant_idx_r  <= {IDX_W{1'b0}};
            last_grant_r <= LAST_RESET;
            hold_count_r <= {HOLD_W{1'b0}};
            preempted_r  <= 1'b0;
            granted_r    <= {CHANNELS{1'b0}};
            enabled_r    <= 1'b0;
        end else begin
            state_r      <= state_n;
            grant_idx_r  <= grant_idx_n;
            last_grant_r <= last_grant_n;
            hold_count_r <= hold_count_n;
            preempted_r  <= preempted_n;
            granted_r    <= granted_n;
            enabled_r    <= enabled_n;
        end
    end

    // Bus mux: the granted channel's inputs pass straight through; zeros when idle
    always_comb begin
        address_s = {ADDR_W{1'b0}};
        data_s    = {DATA_W{1'b0}};
        rw_s      = 1'b0;
        if (enabled_r) begin
            address_s = addrIn[int'(grant_idx_r) * ADDR_W +: ADDR_W];
            data_s    = dataIn[int'(grant_idx_r) * DATA_W +: DATA_W];
            rw_s      = readWriteIn[grant_idx_r];
        end else begin
            rw_s = 1'b0;
        end
    end

    assign grantedAccess = granted_r;
    assign enabled       = enabled_r;
    assign preempted     = preempted_r;
    assign address       = address_s;
    assign dataToMem     = data_s;
    assign readWrite     = rw_s;

endmodule
